// File: rtl/pipe_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline plus LSU wait watchdog and stall counter.
// Latency: stall/flush/mem_timeout are combinational (0 cycles); FSM, wait counter, perf counter registered.
// Backpressure: a busy memory access holds PC..EX_MEM and bubbles MEM_WB until the access completes.
module pipe_ctrl #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_rs1_en,
  input  logic [4:0]        id_rs1_addr,
  input  logic              id_rs2_en,
  input  logic [4:0]        id_rs2_addr,
  input  logic              ex_rw_en,
  input  logic [4:0]        ex_rw_addr,
  input  logic              ex_is_load,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic [4:0]        stall,
  output logic [4:0]        flush,
  output logic              mem_timeout,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [0:0] S_RUN      = 1'b0;
  localparam logic [0:0] S_MEM_WAIT = 1'b1;

  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [PERF_W-1:0] PERF_MAX  = '1;

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

  logic       mem_busy;
  logic       lu_hit;
  logic       wd_expire;
  logic [4:0] stall_raw;
  logic [4:0] flush_raw;

  // Hazard detection; r0 is hardwired zero so it never creates a dependency.
  always_comb begin
    mem_busy  = mem_req & ~mem_ready;
    lu_hit    = ex_is_load & ex_rw_en & (ex_rw_addr != 5'd0) &
                ((id_rs1_en & (id_rs1_addr == ex_rw_addr)) |
                 (id_rs2_en & (id_rs2_addr == ex_rw_addr)));
    wd_expire = mem_busy & (wait_cnt_q == WAIT_LAST);
  end

  // Fixed-priority stall/flush selection: memory wait, then branch, then load-use.
  // A branch held under a memory stall gets flushed once the access completes,
  // since ex_branch_taken is still asserted by the held EX instruction.
  always_comb begin
    stall_raw = 5'b00000;
    flush_raw = 5'b00000;
    if (mem_busy) begin
      stall_raw = 5'b01111;
      flush_raw = 5'b10000;
    end else if (ex_branch_taken) begin
      flush_raw = 5'b00110;
    end else if (lu_hit) begin
      stall_raw = 5'b00011;
      flush_raw = 5'b00100;
    end
  end

  // Outputs are forced quiet while reset is held.
  always_comb begin
    stall       = rst ? 5'b00000 : stall_raw;
    flush       = rst ? 5'b00000 : flush_raw;
    mem_timeout = ~rst & wd_expire;
    stall_cycles = stall_cycles_q;
  end

  // Next-state for the wait FSM, watchdog counter and saturating stall counter.
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    stall_cycles_d = stall_cycles_q;
    if (rst) begin
      state_d        = S_RUN;
      wait_cnt_d     = '0;
      stall_cycles_d = '0;
    end else begin
      case (state_q)
        S_RUN:      if (mem_busy)  state_d = S_MEM_WAIT;
        S_MEM_WAIT: if (!mem_busy) state_d = S_RUN;
        default:    state_d = S_RUN;
      endcase
      // Counter wraps to zero on expiry so the pulse repeats every TIMEOUT busy cycles.
      if (!mem_busy || wd_expire) wait_cnt_d = '0;
      else                        wait_cnt_d = wait_cnt_q + 1'b1;
      if ((|stall_raw) && (stall_cycles_q != PERF_MAX))
        stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  // State registers, synchronous reset folded into the _d logic above.
  always_ff @(posedge clk) begin
    state_q        <= state_d;
    wait_cnt_q     <= wait_cnt_d;
    stall_cycles_q <= stall_cycles_d;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a small watchdog and a narrow perf counter.
// Inputs change 1ns after the rising edge; combinational outputs are checked 1ns later.
// Registered state is checked 1ns after the following rising edge.
module tb_pipe_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 16;
  localparam int PERF_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_rs1_en, id_rs2_en, ex_rw_en, ex_is_load, ex_branch_taken;
  logic [4:0]        id_rs1_addr, id_rs2_addr, ex_rw_addr;
  logic              mem_req, mem_ready;
  logic [4:0]        stall, flush;
  logic              mem_timeout;
  logic [PERF_W-1:0] stall_cycles;

  int vectors   = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_en(id_rs1_en), .id_rs1_addr(id_rs1_addr),
    .id_rs2_en(id_rs2_en), .id_rs2_addr(id_rs2_addr),
    .ex_rw_en(ex_rw_en), .ex_rw_addr(ex_rw_addr),
    .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .stall(stall), .flush(flush), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles)
  );

  task automatic clear_inputs();
    id_rs1_en = 0; id_rs1_addr = 0; id_rs2_en = 0; id_rs2_addr = 0;
    ex_rw_en = 0; ex_rw_addr = 0; ex_is_load = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; mem_req = 1; ex_branch_taken = 1;
    #1;
    vectors++;
    if (stall !== 5'b00000) begin miscompares++; $display("FAIL rst_stall got %b exp 00000", stall); end
    vectors++;
    if (flush !== 5'b00000) begin miscompares++; $display("FAIL rst_flush got %b exp 00000", flush); end
    vectors++;
    if (mem_timeout !== 1'b0) begin miscompares++; $display("FAIL rst_timeout got %b exp 0", mem_timeout); end
    tick();
    vectors++;
    if (stall_cycles !== 4'd0) begin miscompares++; $display("FAIL rst_perf got %0d exp 0", stall_cycles); end
    vectors++;
    if (dut.state_q !== 1'b0) begin miscompares++; $display("FAIL rst_state got %b exp 0", dut.state_q); end
    vectors++;
    if (dut.wait_cnt_q !== 16'd0) begin miscompares++; $display("FAIL rst_wait got %0d exp 0", dut.wait_cnt_q); end
    clear_inputs();
    rst = 0;
  endtask

  task automatic test_load_use();
    do_reset();
    ex_is_load = 1; ex_rw_en = 1; ex_rw_addr = 5; id_rs2_en = 1; id_rs2_addr = 5;
    #1;
    vectors++;
    if (stall !== 5'b00011) begin miscompares++; $display("FAIL lu_stall got %b exp 00011", stall); end
    vectors++;
    if (flush !== 5'b00100) begin miscompares++; $display("FAIL lu_flush got %b exp 00100", flush); end
    tick();
    clear_inputs();
    vectors++;
    if (stall_cycles !== 4'd1) begin miscompares++; $display("FAIL lu_perf got %0d exp 1", stall_cycles); end
    // r0 destination never hazards
    ex_is_load = 1; ex_rw_en = 1; ex_rw_addr = 0; id_rs2_en = 1; id_rs2_addr = 0;
    #1;
    vectors++;
    if (stall !== 5'b00000) begin miscompares++; $display("FAIL lu_r0_stall got %b exp 00000", stall); end
    vectors++;
    if (flush !== 5'b00000) begin miscompares++; $display("FAIL lu_r0_flush got %b exp 00000", flush); end
    tick();
    vectors++;
    if (stall_cycles !== 4'd1) begin miscompares++; $display("FAIL lu_r0_perf got %0d exp 1", stall_cycles); end
    // rs1 match also hazards
    clear_inputs();
    ex_is_load = 1; ex_rw_en = 1; ex_rw_addr = 7; id_rs1_en = 1; id_rs1_addr = 7;
    #1;
    vectors++;
    if (stall !== 5'b00011) begin miscompares++; $display("FAIL lu_rs1_stall got %b exp 00011", stall); end
    // non-load producer does not stall
    ex_is_load = 0;
    #1;
    vectors++;
    if (stall !== 5'b00000) begin miscompares++; $display("FAIL lu_noload_stall got %b exp 00000", stall); end
    // rs1 enable off masks a matching address
    ex_is_load = 1; id_rs1_en = 0;
    #1;
    vectors++;
    if (stall !== 5'b00000) begin miscompares++; $display("FAIL lu_noen_stall got %b exp 00000", stall); end
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      vectors++;
      if (stall !== 5'b01111) begin miscompares++; $display("FAIL mw_stall c%0d got %b exp 01111", i, stall); end
      vectors++;
      if (flush !== 5'b10000) begin miscompares++; $display("FAIL mw_flush c%0d got %b exp 10000", i, flush); end
      tick();
      vectors++;
      if (dut.state_q !== 1'b1) begin miscompares++; $display("FAIL mw_state c%0d got %b exp 1", i, dut.state_q); end
    end
    mem_ready = 1;
    #1;
    vectors++;
    if (stall !== 5'b00000) begin miscompares++; $display("FAIL mw_done_stall got %b exp 00000", stall); end
    vectors++;
    if (flush !== 5'b00000) begin miscompares++; $display("FAIL mw_done_flush got %b exp 00000", flush); end
    tick();
    vectors++;
    if (dut.state_q !== 1'b0) begin miscompares++; $display("FAIL mw_done_state got %b exp 0", dut.state_q); end
    vectors++;
    if (stall_cycles !== 4'd3) begin miscompares++; $display("FAIL mw_perf got %0d exp 3", stall_cycles); end
    // zero-wait access from RUN: no stall, no state change
    #1;
    vectors++;
    if (stall !== 5'b00000) begin miscompares++; $display("FAIL zw_stall got %b exp 00000", stall); end
    tick();
    vectors++;
    if (dut.state_q !== 1'b0) begin miscompares++; $display("FAIL zw_state got %b exp 0", dut.state_q); end
    vectors++;
    if (stall_cycles !== 4'd3) begin miscompares++; $display("FAIL zw_perf got %0d exp 3", stall_cycles); end
    clear_inputs();
  endtask

  task automatic test_branch_under_mem();
    do_reset();
    mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
    for (int i = 1; i <= 2; i++) begin
      #1;
      vectors++;
      if (flush !== 5'b10000) begin miscompares++; $display("FAIL bm_flush c%0d got %b exp 10000", i, flush); end
      vectors++;
      if (stall !== 5'b01111) begin miscompares++; $display("FAIL bm_stall c%0d got %b exp 01111", i, stall); end
      tick();
    end
    mem_ready = 1;
    #1;
    vectors++;
    if (flush !== 5'b00110) begin miscompares++; $display("FAIL bm_release_flush got %b exp 00110", flush); end
    vectors++;
    if (stall !== 5'b00000) begin miscompares++; $display("FAIL bm_release_stall got %b exp 00000", stall); end
    tick();
    clear_inputs();
  endtask

  task automatic test_branch_vs_lu();
    do_reset();
    ex_branch_taken = 1;
    ex_is_load = 1; ex_rw_en = 1; ex_rw_addr = 9; id_rs1_en = 1; id_rs1_addr = 9;
    #1;
    vectors++;
    if (stall !== 5'b00000) begin miscompares++; $display("FAIL blu_stall got %b exp 00000", stall); end
    vectors++;
    if (flush !== 5'b00110) begin miscompares++; $display("FAIL blu_flush got %b exp 00110", flush); end
    tick();
    vectors++;
    if (stall_cycles !== 4'd0) begin miscompares++; $display("FAIL blu_perf got %0d exp 0", stall_cycles); end
    clear_inputs();
  endtask

  task automatic test_watchdog();
    logic exp_to;
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 1; i <= 9; i++) begin
      exp_to = (i == 4) || (i == 8);
      #1;
      vectors++;
      if (mem_timeout !== exp_to) begin miscompares++; $display("FAIL wd_pulse c%0d got %b exp %b", i, mem_timeout, exp_to); end
      tick();
      vectors++;
      if (dut.wait_cnt_q !== 16'(i % 4)) begin miscompares++; $display("FAIL wd_cnt c%0d got %0d exp %0d", i, dut.wait_cnt_q, i % 4); end
    end
    vectors++;
    if (dut.state_q !== 1'b1) begin miscompares++; $display("FAIL wd_state got %b exp 1", dut.state_q); end
    clear_inputs();

    // reset lands on busy cycle 6; watchdog restarts from zero afterwards
    do_reset();
    mem_req = 1;
    for (int i = 1; i <= 8; i++) begin
      exp_to = (i == 4);
      rst = (i == 6);
      #1;
      vectors++;
      if (mem_timeout !== exp_to) begin miscompares++; $display("FAIL wdr_pulse c%0d got %b exp %b", i, mem_timeout, exp_to); end
      if (i == 6) begin
        vectors++;
        if (stall !== 5'b00000) begin miscompares++; $display("FAIL wdr_stall got %b exp 00000", stall); end
      end
      tick();
      if (i == 6) begin
        vectors++;
        if (dut.state_q !== 1'b0) begin miscompares++; $display("FAIL wdr_state got %b exp 0", dut.state_q); end
        vectors++;
        if (dut.wait_cnt_q !== 16'd0) begin miscompares++; $display("FAIL wdr_cnt got %0d exp 0", dut.wait_cnt_q); end
      end
    end
    rst = 0;
    clear_inputs();
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_cnt = (i > 15) ? 15 : i;
      vectors++;
      if (stall_cycles !== 4'(exp_cnt)) begin miscompares++; $display("FAIL sat c%0d got %0d exp %0d", i, stall_cycles, exp_cnt); end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    #2;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_branch_under_mem();
    test_branch_vs_lu();
    test_watchdog();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
